clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parametrised bank of NUM_CH independent clock dividers, each with a runtime-programmable divisor, per-channel enable and a single-cycle tick output alongside the divided square wave. It is the general-purpose successor to the fixed-divisor divider and drives the stopwatch/display logic (1 Hz, 2 Hz, blink, seven-segment scan) from the 100 MHz board clock. The tick outputs are clock enables; downstream logic stays on clk.

## Interface
- NUM_CH, 4, number of divider channels (1..16)
- CNT_W, 32, counter and divisor width
- DIV_INIT, 50_000, divisor loaded into every channel at reset (must be >= 1)
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset, asynchronous, active-low
- en  in  NUM_CH  per-channel run enable
- sync_clr  in  1  synchronous phase-align clear of all channels
- cfg_valid  in  1  divisor-update request
- cfg_ready  out  1  bank can accept an update
- cfg_ch  in  CH_W = max(1, clog2(NUM_CH))  target channel
- cfg_div  in  CNT_W  new divisor (half-period in clk cycles)
- cfg_mode  in  1  0 = deferred (apply at next wrap), 1 = immediate
- tick  out  NUM_CH  one-cycle pulse at each half-period boundary
- clk_div  out  NUM_CH  divided square wave, f_clk / (2 * div)
- cfg_err  out  1  one-cycle pulse: rejected update

## Operation
- Per channel: counter cnt, divisor div, pending divisor pdiv, pending flag pend.
- Enabled channel: cnt increments each cycle; at cnt == div-1 it wraps to 0, clk_div toggles, tick pulses. div = 1 gives toggle every cycle (f_clk/2).
- Disabled channel: cnt and clk_div hold, tick = 0.
- Update accepted when cfg_valid && cfg_ready. cfg_ready = !sync_clr && !pend[cfg_ch] (combinational on cfg_ch).
- Rejected (cfg_err pulses next cycle, no state change): cfg_div == 0 or cfg_ch >= NUM_CH. Still counts as a completed handshake.
- Immediate mode: next cycle div = cfg_div, cnt = 0, clk_div level retained, no tick; any pend cleared.
- Deferred mode: pdiv = cfg_div, pend = 1; on that channel's next wrap, div = pdiv and pend = 0 in the same edge. If the channel is disabled, deferred update applies on the next cycle like immediate.
- sync_clr (priority over counting and cfg): all cnt = 0, clk_div = 0, tick = 0; pending divisors applied and pend cleared.

## Timing
- Reset values: cnt = 0, div = DIV_INIT, pend = 0, clk_div = 0, tick = 0, cfg_err = 0; cfg_ready = 1 after reset deasserts.
- tick and clk_div are registered; both change on the edge where cnt wraps.
- With en high from reset release: first tick/toggle on the div-th rising edge, then every div edges.
- Reset asserted mid-count: all state returns to reset values immediately; no tick on release.
- en deassert on the wrap edge: the wrap completes (en sampled same edge as counter); subsequent cycles hold.
- Divisor change never produces a tick shorter than one cycle or a glitch on clk_div (registered output).
- Update to a channel whose cnt >= new div in deferred mode is safe: applies only at wrap.

## Structure
- Package clk_div_pkg: CNT_W default, DIV_INIT default, CFG_MODE_DEFERRED = 0 / CFG_MODE_IMMEDIATE = 1 constants.
- Sub-module div_channel: one counter/divisor/pending slice with load, load_mode, en, clr inputs and tick, clk_div outputs; instantiated NUM_CH times via generate. Top level holds cfg decode, ready and error logic.

## Test plan
- Reset, en = 4'b0001, DIV_INIT = 4 -> tick[0] at edges 4, 8, 12; clk_div[0] 0->1 at edge 4, 1->0 at edge 8; other channels silent.
- Immediate update ch1 to div = 3 while cnt = 7 of div = 10 -> cnt resets, next tick[1] exactly 3 edges later, clk_div[1] level unchanged at load.
- Deferred update ch2 div = 2 mid-period of div = 5 -> cfg_ready low for ch2 until wrap; wrap at original 5-cycle point, then ticks every 2 cycles.
- cfg_div = 0 and cfg_ch = NUM_CH -> cfg_err pulses one cycle each, all divisors unchanged.
- sync_clr with pending update on ch0 and channels at mixed phases -> all clk_div = 0, pending applied, all enabled channels tick together div edges later; cfg_ready low during sync_clr.
- rst pulsed low mid-period -> outputs clear asynchronously, div back to DIV_INIT.

Source files
------------

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the clock divider bank
//
// Purpose : default widths/divisor, update-mode encoding and the channel-index
//           width helper used by clk_div_bank and div_channel.
// Ports   : none (package).

package clk_div_pkg;

    localparam int CNT_W_DEFAULT    = 32;
    localparam int DIV_INIT_DEFAULT = 50_000;

    // cfg_mode encoding: deferred updates wait for the channel's next wrap,
    // immediate updates restart the channel's count on the next edge.
    typedef enum logic {
        CFG_MODE_DEFERRED  = 1'b0,
        CFG_MODE_IMMEDIATE = 1'b1
    } cfg_mode_e;

    // Channel-select width; a single-channel bank still gets a 1-bit select
    // so that cfg_ch = 1 can be recognised as out of range.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_channel.sv
// rtl/div_channel.sv - one divider slice: counter, divisor, pending divisor
//
// Purpose : counts enabled cycles, wraps at div-1, toggles clk_div and pulses
//           tick on each wrap; accepts immediate or deferred divisor loads.
// Ports   : clk, rst (async active-low)
//           en        run enable
//           clr       synchronous phase-align clear (highest priority)
//           load      accepted divisor update for this channel
//           load_mode 0 = deferred, 1 = immediate
//           load_div  new divisor (>= 1, checked by the bank)
//           tick      one-cycle pulse on wrap (registered)
//           clk_div   divided square wave (registered)
//           pend      a deferred divisor is waiting for the next wrap

module div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int DIV_INIT = DIV_INIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic             load_mode,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             clk_div,
    output logic             pend
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pdiv;
    logic             wrap;
    logic             load_now;

    // div is never 0 (reset value >= 1 and the bank rejects 0), so div-1
    // never underflows.
    assign wrap = (cnt == div - CNT_W'(1));

    // A deferred load to a stopped channel would otherwise wait forever for
    // a wrap, so it takes effect straight away like an immediate load.
    assign load_now = load && ((load_mode == CFG_MODE_IMMEDIATE) || !en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            div     <= CNT_W'(DIV_INIT);
            pdiv    <= CNT_W'(DIV_INIT);
            pend    <= 1'b0;
            tick    <= 1'b0;
            clk_div <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clr) begin
                cnt     <= '0;
                clk_div <= 1'b0;
                if (pend) begin
                    div  <= pdiv;
                    pend <= 1'b0;
                end
            end else if (load_now) begin
                // Restart the period with the new divisor; the output level
                // is kept and no tick is issued even if this was a wrap edge.
                div  <= load_div;
                cnt  <= '0;
                pend <= 1'b0;
            end else begin
                if (en) begin
                    if (wrap) begin
                        cnt     <= '0;
                        clk_div <= ~clk_div;
                        tick    <= 1'b1;
                        if (pend) begin
                            div  <= pdiv;
                            pend <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else if (pend) begin
                    // Channel was stopped while an update was waiting.
                    div  <= pdiv;
                    pend <= 1'b0;
                    cnt  <= '0;
                end

                // Loads only arrive while pend is clear, so this never races
                // with the pending-apply above.
                if (load) begin
                    pdiv <= load_div;
                    pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of NUM_CH programmable clock dividers
//
// Purpose : NUM_CH independent divider channels sharing one configuration
//           port; decodes the update handshake, rejects bad updates and
//           fans loads out to the addressed channel.
// Ports   : clk, rst (async active-low)
//           en[NUM_CH]      per-channel run enable
//           sync_clr        phase-align clear of all channels
//           cfg_valid/ready divisor update handshake
//           cfg_ch          target channel
//           cfg_div         new half-period in clk cycles
//           cfg_mode        0 = deferred, 1 = immediate
//           tick[NUM_CH]    one-cycle pulse per half-period
//           clk_div[NUM_CH] divided square wave
//           cfg_err         one-cycle pulse after a rejected update

module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int CNT_W    = CNT_W_DEFAULT,
    parameter  int DIV_INIT = DIV_INIT_DEFAULT,
    localparam int CH_W     = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_div,
    output logic              cfg_err
);

    logic [NUM_CH-1:0]        pend;
    logic [NUM_CH-1:0]        load;
    logic [(1 << CH_W)-1:0]   pend_ext;
    logic                     cfg_accept;
    logic                     cfg_bad;
    logic                     cfg_ok;

    // Zero-pad the pending flags to the full select range so an
    // out-of-range cfg_ch reads "not pending" and can complete (and be
    // rejected) instead of stalling the port.
    always_comb begin
        pend_ext             = '0;
        pend_ext[NUM_CH-1:0] = pend;
    end

    assign cfg_ready  = !sync_clr && !pend_ext[cfg_ch];
    assign cfg_accept = cfg_valid && cfg_ready;
    assign cfg_bad    = (cfg_div == '0) || ({1'b0, cfg_ch} >= (CH_W + 1)'(NUM_CH));
    assign cfg_ok     = cfg_accept && !cfg_bad;

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ok && (cfg_ch == CH_W'(i))) begin
                load[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_accept && cfg_bad;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        div_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en[i]),
            .clr       (sync_clr),
            .load      (load[i]),
            .load_mode (cfg_mode),
            .load_div  (cfg_div),
            .tick      (tick[i]),
            .clk_div   (clk_div[i]),
            .pend      (pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - self-checking bench for clk_div_bank

module tb_clk_div_bank;

    localparam int NUM_CH   = 5;
    localparam int CNT_W    = 16;
    localparam int DIV_INIT = 4;
    localparam int CH_W     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              sync_clr;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_div;
    logic              cfg_err;

    clk_div_bank #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync_clr  (sync_clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .tick      (tick),
        .clk_div   (clk_div),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    // Reference model: each channel tracks how many enabled cycles remain
    // until its next half-period boundary.
    int                m_div  [NUM_CH];
    int                m_rem  [NUM_CH];
    int                m_pdiv [NUM_CH];
    bit                m_pend [NUM_CH];
    logic [NUM_CH-1:0] e_tick;
    logic [NUM_CH-1:0] e_lvl;
    logic              e_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_div[c]  = DIV_INIT;
            m_rem[c]  = DIV_INIT;
            m_pdiv[c] = DIV_INIT;
            m_pend[c] = 0;
        end
        e_tick = '0;
        e_lvl  = '0;
        e_err  = 1'b0;
    endtask

    function automatic bit model_ready();
        if (sync_clr) return 1'b0;
        if (int'(cfg_ch) < NUM_CH && m_pend[int'(cfg_ch)]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_advance();
        bit acc;
        bit bad;
        bit ld;
        if (!rst) begin
            model_reset();
            return;
        end
        acc   = cfg_valid && model_ready();
        bad   = (cfg_div == '0) || (int'(cfg_ch) >= NUM_CH);
        e_err = acc && bad;
        for (int c = 0; c < NUM_CH; c++) begin
            e_tick[c] = 1'b0;
            ld = acc && !bad && (int'(cfg_ch) == c);
            if (sync_clr) begin
                if (m_pend[c]) begin
                    m_div[c]  = m_pdiv[c];
                    m_pend[c] = 0;
                end
                m_rem[c] = m_div[c];
                e_lvl[c] = 1'b0;
            end else if (ld && (cfg_mode || !en[c])) begin
                m_div[c]  = int'(cfg_div);
                m_rem[c]  = m_div[c];
                m_pend[c] = 0;
            end else begin
                if (en[c]) begin
                    m_rem[c]--;
                    if (m_rem[c] == 0) begin
                        e_tick[c] = 1'b1;
                        e_lvl[c]  = ~e_lvl[c];
                        if (m_pend[c]) begin
                            m_div[c]  = m_pdiv[c];
                            m_pend[c] = 0;
                        end
                        m_rem[c] = m_div[c];
                    end
                end else if (m_pend[c]) begin
                    m_div[c]  = m_pdiv[c];
                    m_pend[c] = 0;
                    m_rem[c]  = m_div[c];
                end
                if (ld) begin
                    m_pdiv[c] = int'(cfg_div);
                    m_pend[c] = 1;
                end
            end
        end
    endtask

    // Inputs change 1 time unit after each rising edge, so the model sees
    // the same values the DUT sampled.
    task automatic tick_clk();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        model_reset();
        cfg_valid = 1'b0;
        sync_clr  = 1'b0;
        en        = '0;
        tick_clk();
        tick_clk();
        rst = 1'b1;
    endtask

    task automatic cfg(input int ch, input int dv, input bit mode);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(dv);
        cfg_mode  = mode;
        tick_clk();
        cfg_valid = 1'b0;
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("tick",      32'(tick),      32'(e_tick));
                check("clk_div",   32'(clk_div),   32'(e_lvl));
                check("cfg_err",   32'(cfg_err),   32'(e_err));
                check("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
            end
        end
    end

    initial begin
        rst = 1'b0; en = '0; sync_clr = 1'b0; cfg_valid = 1'b0;
        cfg_mode = 1'b0; cfg_ch = '0; cfg_div = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk_on = 1;

        // Reset state
        check("rst_tick",    32'(tick),      32'(0));
        check("rst_clk_div", 32'(clk_div),   32'(0));
        check("rst_cfg_err", 32'(cfg_err),   32'(0));
        check("rst_ready",   32'(cfg_ready), 32'(1));
        tick_clk();

        // Channel 0 alone with the reset divisor of 4
        rst = 1'b1;
        en  = NUM_CH'(1);
        for (int k = 1; k <= 12; k++) begin
            tick_clk();
            check("t1_tick0",  32'(tick[0]),          32'(k % 4 == 0));
            check("t1_clk0",   32'(clk_div[0]),       32'((k / 4) % 2));
            check("t1_others", 32'(tick[NUM_CH-1:1]), 32'(0));
        end

        // Immediate update at cnt = 7 of div = 10
        do_reset();
        en = NUM_CH'(2);
        cfg(1, 10, 1'b1);
        repeat (7) tick_clk();
        cfg(1, 3, 1'b1);
        check("t2_lvl_kept", 32'(clk_div[1]), 32'(0));
        check("t2_no_tick",  32'(tick[1]),    32'(0));
        for (int k = 1; k <= 3; k++) begin
            tick_clk();
            check("t2_tick1", 32'(tick[1]), 32'(k == 3));
        end

        // Deferred update mid-period of div = 5
        do_reset();
        en = NUM_CH'(4);
        cfg(2, 5, 1'b1);
        repeat (2) tick_clk();
        cfg(2, 2, 1'b0);
        check("t3_ready_low", 32'(cfg_ready), 32'(0));
        for (int k = 1; k <= 6; k++) begin
            tick_clk();
            check("t3_tick2",  32'(tick[2]),   32'(k % 2 == 0));
            check("t3_ready",  32'(cfg_ready), 32'(k >= 2));
        end

        // Rejected updates leave divisors alone
        do_reset();
        en = NUM_CH'(1);
        cfg(0, 0, 1'b1);
        check("t4_err_zero", 32'(cfg_err), 32'(1));
        tick_clk();
        check("t4_err_clr0", 32'(cfg_err), 32'(0));
        cfg(NUM_CH, 7, 1'b1);
        check("t4_err_ch",   32'(cfg_err), 32'(1));
        tick_clk();
        check("t4_err_clr1", 32'(cfg_err), 32'(0));
        check("t4_div_kept", 32'(tick[0]), 32'(1));

        // sync_clr with a pending update and mixed phases
        do_reset();
        en = '1;
        cfg(1, 3, 1'b1);
        cfg(2, 6, 1'b1);
        tick_clk();
        cfg(0, 7, 1'b0);
        sync_clr = 1'b1;
        cfg_ch   = CH_W'(3);
        #1;
        check("t5_ready_clr", 32'(cfg_ready), 32'(0));
        tick_clk();
        sync_clr = 1'b0;
        check("t5_clk_div", 32'(clk_div), 32'(0));
        check("t5_tick",    32'(tick),    32'(0));
        for (int k = 1; k <= 7; k++) begin
            tick_clk();
            check("t5_tick0", 32'(tick[0]), 32'(k == 7));
            check("t5_tick1", 32'(tick[1]), 32'(k == 3 || k == 6));
            check("t5_tick3", 32'(tick[3]), 32'(k == 4));
        end

        // Reset pulsed mid-period
        do_reset();
        en = '1;
        repeat (6) tick_clk();
        rst = 1'b0;
        model_reset();
        #1;
        check("t6_async_clk", 32'(clk_div), 32'(0));
        check("t6_async_tck", 32'(tick),    32'(0));
        tick_clk();
        tick_clk();
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick_clk();
            check("t6_tick0", 32'(tick[0]), 32'(k == 4));
        end

        // Randomised traffic against the model
        do_reset();
        en = '1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) en = NUM_CH'($urandom);
            sync_clr  = ($urandom_range(0, 49) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 7));
            cfg_div   = CNT_W'($urandom_range(0, 9));
            cfg_mode  = 1'($urandom_range(0, 1));
            tick_clk();
        end

        sync_clr  = 1'b0;
        cfg_valid = 1'b0;
        tick_clk();
        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
